mtm_alu_serializer: RTL

MTM_ALU_SERIALIZER -- requirements
Module: mtm_Alu_serializer

---
 rtl/mtm_alu_serializer_pkg.sv | 31 +++
 rtl/mtm_alu_serializer.sv | 67 ++++++
 2 files changed

// File: rtl/mtm_alu_serializer_pkg.sv
// Shared definitions for the ALU result serializer: FSM encodings,
// word/frame geometry and the frame assembly helper.
package mtm_Alu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic WORD_DATA = 1'b0;
  localparam logic WORD_CTL  = 1'b1;
  localparam int   WORD_LEN  = 11;
  localparam int   FRAME_LEN = 55;

  // One 11-bit word: start 0, type bit, 8 payload bits MSB first, stop 1.
  function automatic logic [WORD_LEN-1:0] make_word(input logic t, input logic [7:0] p);
    return {1'b0, t, p, 1'b1};
  endfunction

  // Full frame with the first transmitted bit in the MSB position.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [31:0] c,
                                                       input logic [3:0]  flg,
                                                       input logic [2:0]  crc);
    return {make_word(WORD_DATA, c[31:24]),
            make_word(WORD_DATA, c[23:16]),
            make_word(WORD_DATA, c[15:8]),
            make_word(WORD_DATA, c[7:0]),
            make_word(WORD_CTL, {1'b0, flg, crc})};
  endfunction

endpackage

// File: rtl/mtm_alu_serializer.sv
// Serializes an ALU result (4 DATA words + 1 CTL word) onto a one-bit line,
// one bit per clock, idle high. A new request may be accepted on the edge
// that ends the previous frame, giving back-to-back frames with no gap.
module mtm_alu_serializer
  import mtm_Alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_data,
  input  logic [31:0] C_in,
  input  logic [3:0]  flg_in,
  input  logic [2:0]  crc_in,
  output logic        sout,
  output logic        busy
);

  localparam logic [5:0] LAST_BIT = 6'(FRAME_LEN - 1);

  state_t                 r_state;
  logic                   r_sout;
  logic                   r_busy;
  logic [5:0]             r_cnt;
  logic [FRAME_LEN-1:0]   r_shift;

  logic [FRAME_LEN-1:0]   w_frame;
  logic                   w_last;
  logic                   w_load;

  assign w_frame = build_frame(C_in, flg_in, crc_in);
  assign w_last  = (r_state == ST_SEND) && (r_cnt == LAST_BIT);
  // Requests are honoured only when idle or on the edge that retires the
  // final stop bit; anything earlier in a frame is dropped.
  assign w_load  = send_data && ((r_state == ST_IDLE) || w_last);

  // Frame FSM: load on request, shift one bit per clock, return to idle after bit 54.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sout  <= 1'b1;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '1;
    end else if (w_load) begin
      r_state <= ST_SEND;
      r_sout  <= w_frame[FRAME_LEN-1];
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_shift <= {w_frame[FRAME_LEN-2:0], 1'b1};
    end else if (r_state == ST_SEND) begin
      if (w_last) begin
        r_state <= ST_IDLE;
        r_sout  <= 1'b1;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
        r_shift <= '1;
      end else begin
        r_sout  <= r_shift[FRAME_LEN-1];
        r_cnt   <= r_cnt + 6'd1;
        r_shift <= {r_shift[FRAME_LEN-2:0], 1'b1};
      end
    end
  end

  assign sout = r_sout;
  assign busy = r_busy;

endmodule
